// File: rtl/inst_loader.sv
// Host-stream instruction loader: parses a length header, then packs (lo, hi) word pairs
// into instructions and strobes them into instruction memory at sequential addresses.
module inst_loader #(
  parameter int unsigned INST_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned INST_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_W-1:0]     inst_addr,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  // One extra bit so a full-depth length (INST_DEPTH itself) is representable.
  localparam int unsigned LenW = ADDR_W + 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLo   = 3'd1;
  localparam logic [2:0] StHi   = 3'd2;
  localparam logic [2:0] StDone = 3'd3;
  localparam logic [2:0] StErr  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_W-1:0]     count_q, count_d;
  logic [LenW-1:0]       length_q, length_d;
  logic [WORD_WIDTH-1:0] lo_q, lo_d;
  logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0]     inst_addr_q, inst_addr_d;
  logic                  inst_valid_q, inst_valid_d;

  logic        beat;
  logic [15:0] header;
  logic        header_bad;
  logic        last_pair;

  assign in_ready   = (state_q == StIdle) || (state_q == StLo) || (state_q == StHi);
  assign busy       = (state_q == StLo) || (state_q == StHi);
  assign load_done  = (state_q == StDone);
  assign load_err   = (state_q == StErr);
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_addr  = inst_addr_q;

  assign beat       = in_valid && in_ready;
  assign header     = in_data[15:0];
  assign header_bad = (header == 16'd0) || (header > 16'(INST_DEPTH));
  assign last_pair  = ({1'b0, count_q} == (length_q - LenW'(1)));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    length_d     = length_q;
    lo_d         = lo_q;
    inst_out_d   = inst_out_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = 1'b0;

    if (clear) begin
      // Abandons any partial program; last written instruction/address stay visible.
      state_d = StIdle;
      count_d = '0;
      lo_d    = '0;
    end else if (beat) begin
      case (state_q)
        StIdle: begin
          if (header_bad) begin
            state_d = StErr;
          end else begin
            length_d = header[LenW-1:0];
            count_d  = '0;
            state_d  = StLo;
          end
        end
        StLo: begin
          lo_d    = in_data;
          state_d = StHi;
        end
        StHi: begin
          inst_out_d   = {in_data, lo_q};
          inst_addr_d  = count_q;
          inst_valid_d = 1'b1;
          if (last_pair) begin
            state_d = StDone;
          end else begin
            count_d = count_q + ADDR_W'(1);
            state_d = StLo;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      length_q     <= '0;
      lo_q         <= '0;
      inst_out_q   <= '0;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      length_q     <= length_d;
      lo_q         <= lo_d;
      inst_out_q   <= inst_out_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: vector table for the straight-line loads and header errors,
// hand sequences for gapped input, clear mid-load, full depth and asynchronous reset.
module tb_inst_loader;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        inst_valid;
  logic [63:0] inst_out;
  logic [3:0]  inst_addr;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int compared   = 0;
  int mismatched = 0;

  inst_loader #(
    .INST_WIDTH(64),
    .WORD_WIDTH(32),
    .INST_DEPTH(16),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .inst_valid(inst_valid),
    .inst_out(inst_out),
    .inst_addr(inst_addr),
    .busy(busy),
    .load_done(load_done),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        clr;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_out;
    logic [3:0]  e_addr;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vld, input logic [31:0] data, input logic clr,
                              input logic rdy, input logic val, input logic [63:0] out,
                              input logic [3:0] addr, input logic bsy, input logic dn,
                              input logic er);
    vec_t v;
    v.vld = vld; v.data = data; v.clr = clr; v.e_ready = rdy; v.e_valid = val;
    v.e_out = out; v.e_addr = addr; v.e_busy = bsy; v.e_done = dn; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic step(input logic vld, input logic [31:0] data, input logic clr);
    in_valid = vld;
    in_data  = data;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic val,
                           input logic [63:0] out, input logic [3:0] addr, input logic bsy,
                           input logic dn, input logic er);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(val));
    chk({tag, ".inst_out"}, inst_out, out);
    chk({tag, ".inst_addr"}, 64'(inst_addr), 64'(addr));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    chk({tag, ".load_done"}, 64'(load_done), 64'(dn));
    chk({tag, ".load_err"}, 64'(load_err), 64'(er));
  endtask

  logic [31:0] los [5];
  logic [63:0] prev_out;
  logic [63:0] exp_out;
  int          pulses;

  initial begin
    los[0] = 32'hffff0000; los[1] = 32'hffffaaaa; los[2] = 32'hffffbbbb;
    los[3] = 32'hffffcccc; los[4] = 32'hffffdddd;

    // Test 1: header 5 then five pairs back-to-back.
    tbl.push_back(mk(1'b1, 32'd5, 1'b0, 1'b1, 1'b0, 64'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      prev_out = (k == 0) ? 64'h0 : {32'h0, los[k-1]};
      tbl.push_back(mk(1'b1, los[k], 1'b0, 1'b1, 1'b0, prev_out,
                       (k == 0) ? 4'd0 : 4'(k - 1), 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 32'h0, 1'b0, (k != 4), 1'b1, {32'h0, los[k]}, 4'(k),
                       (k != 4), (k == 4), 1'b0));
    end
    exp_out = {32'h0, los[4]};
    tbl.push_back(mk(1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, exp_out, 4'd4, 1'b0, 1'b1, 1'b0));
    // Test 2: illegal headers 0 and 17.
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, exp_out, 4'd4, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, exp_out, 4'd4, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, exp_out, 4'd4, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, exp_out, 4'd4, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'd17, 1'b0, 1'b0, 1'b0, exp_out, 4'd4, 1'b0, 1'b0, 1'b1));
    // Header upper bits ignored: ffff0001 is length 1.
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, exp_out, 4'd4, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'hffff0001, 1'b0, 1'b1, 1'b0, exp_out, 4'd4, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, exp_out, 4'd4, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h00000002, 1'b0, 1'b0, 1'b1, 64'h0000000200000001, 4'd0,
                     1'b0, 1'b1, 1'b0));

    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    check_all("reset", 1'b1, 1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].data, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_valid, tbl[i].e_out,
                tbl[i].e_addr, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
    end

    // Test 3: header 2, valid toggling, three idle cycles between lo and hi.
    step(1'b0, 32'h0, 1'b1);
    begin
      logic [31:0] sd [11];
      logic        sv [11];
      sv = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};
      sd = '{32'd2, 32'h0, 32'h11111111, 32'h0, 32'h0, 32'h0, 32'h22222222, 32'h0,
             32'h33333333, 32'h0, 32'h44444444};
      pulses = 0;
      for (int s = 0; s < 11; s++) begin
        step(sv[s], sd[s], 1'b0);
        if (inst_valid) pulses++;
        if (s < 6) exp_out = 64'h0000000200000001;
        else if (s < 10) exp_out = 64'h2222222211111111;
        else exp_out = 64'h4444444433333333;
        chk($sformatf("gap%0d.inst_valid", s), 64'(inst_valid), 64'((s == 6) || (s == 10)));
        chk($sformatf("gap%0d.busy", s), 64'(busy), 64'(s < 10));
        chk($sformatf("gap%0d.inst_out", s), inst_out, exp_out);
        if (s == 6) chk("gap.addr0", 64'(inst_addr), 64'd0);
        if (s == 10) chk("gap.addr1", 64'(inst_addr), 64'd1);
      end
      chk("gap.pulses", 64'(pulses), 64'd2);
      chk("gap.done", 64'(load_done), 64'd1);
    end

    // Test 4: clear coincident with a hi beat abandons the program.
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'd3, 1'b0);
    step(1'b1, 32'haaaa0001, 1'b0);
    step(1'b1, 32'hbbbb0001, 1'b0);
    chk("clr.first_pulse", 64'(inst_valid), 64'd1);
    step(1'b1, 32'haaaa0002, 1'b0);
    step(1'b1, 32'hbbbb0002, 1'b1);
    check_all("clr.after", 1'b1, 1'b0, 64'hbbbb0001aaaa0001, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'h12345678, 1'b0);
    step(1'b1, 32'h9abcdef0, 1'b0);
    check_all("clr.reload", 1'b0, 1'b1, 64'h9abcdef012345678, 4'd0, 1'b0, 1'b1, 1'b0);

    // Test 5: full-depth program of 16 instructions.
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'd16, 1'b0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 32'h10000000 + 32'(k), 1'b0);
      if (inst_valid) pulses++;
      step(1'b1, 32'ha0000000 + 32'(k), 1'b0);
      if (inst_valid) pulses++;
      chk($sformatf("full%0d.addr", k), 64'(inst_addr), 64'(k));
      chk($sformatf("full%0d.out", k), inst_out, {32'ha0000000 + 32'(k), 32'h10000000 + 32'(k)});
    end
    chk("full.pulses", 64'(pulses), 64'd16);
    chk("full.done", 64'(load_done), 64'd1);
    chk("full.ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h55555555, 1'b0);
    step(1'b1, 32'h66666666, 1'b0);
    check_all("full.extra", 1'b0, 1'b0, 64'ha000000f1000000f, 4'd15, 1'b0, 1'b1, 1'b0);

    // Test 6: asynchronous reset after 2 of 4 instructions.
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'd4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 32'h70000000 + 32'(k), 1'b0);
      step(1'b1, 32'h80000000 + 32'(k), 1'b0);
    end
    chk("arst.pre_addr", 64'(inst_addr), 64'd1);
    step(1'b1, 32'h70000002, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst.inst_valid", 64'(inst_valid), 64'd0);
    chk("arst.inst_out", inst_out, 64'h0);
    chk("arst.inst_addr", 64'(inst_addr), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(load_done), 64'd0);
    chk("arst.err", 64'(load_err), 64'd0);
    @(posedge clk); #1;
    chk("arst.no_pulse", 64'(inst_valid), 64'd0);
    rst = 1'b1;
    chk("arst.ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'd1, 1'b0);
    chk("arst.hdr_busy", 64'(busy), 64'd1);
    step(1'b1, 32'hcafe0000, 1'b0);
    step(1'b1, 32'hbeef0000, 1'b0);
    check_all("arst.reload", 1'b0, 1'b1, 64'hbeef0000cafe0000, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream feeder for the instruction memory.
- Accepts a 32-bit host word stream with a valid/ready handshake, parses a length header, and packs word pairs into INST_WIDTH-bit instructions.
- Drives the memory's valid/instruction write interface one instruction per pulse, with a sequential write address.
- Reports load completion, or rejects an illegal program length.

Parameters:
- INST_WIDTH, 64: instruction width; must equal 2*WORD_WIDTH.
- WORD_WIDTH, 32: host word width.
- INST_DEPTH, 16: maximum instructions per program (instruction memory depth).
- ADDR_W, 4: address width; must satisfy 2**ADDR_W >= INST_DEPTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous re-arm; returns the block to IDLE.
- in_valid  input  1  host word valid.
- in_ready  output  1  loader can accept a word.
- in_data  input  WORD_WIDTH  host word.
- inst_valid  output  1  one-cycle write strobe to instruction memory.
- inst_out  output  INST_WIDTH  packed instruction.
- inst_addr  output  ADDR_W  write index of the current inst_out.
- busy  output  1  load in progress (LO or HI state).
- load_done  output  1  level; full program delivered.
- load_err  output  1  level; illegal header.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - inst_valid=0, inst_out=0, inst_addr=0, load_done=0, load_err=0, busy=0.
  - Internal count=0, length=0, lo register=0.
- Beat: in_valid & in_ready sampled high at a rising edge.
- in_ready: combinational from state only. 1 in IDLE/LO/HI, 0 in DONE/ERR. Never depends on in_valid.
- States:
  - IDLE: a beat is the header; N=in_data[15:0], upper bits ignored.
    - N==0 or N>INST_DEPTH -> ERR; load_err=1 next cycle.
    - Otherwise latch length=N, count=0 -> LO.
  - LO: a beat latches lo=in_data -> HI.
  - HI: a beat registers inst_out={in_data, lo}, so the high word is second. The same edge also sets inst_valid=1 and inst_addr=count.
    - If count==length-1 -> DONE; load_done=1 from the same edge.
    - Else count+1 -> LO.
  - DONE: hold; ignore input; in_ready=0.
  - ERR: hold; ignore input; in_ready=0.
- No beat in LO/HI: state, count and lo hold. Gaps between words are unlimited.
- Latency: inst_valid rises the cycle after the HI beat edge and lasts exactly 1 cycle. It is never asserted on consecutive cycles.
- Throughput: minimum 2 cycles per instruction.
- Output hold: inst_out and inst_addr keep their last values while inst_valid=0. They are not zeroed after the pulse.
- busy=1 exactly in LO or HI.
- clear (synchronous): highest priority over any beat in the same cycle.
  - Next state=IDLE; count=0; load_done=0; load_err=0; inst_valid=0.
  - inst_out/inst_addr hold.
  - clear during LO/HI abandons the partial program; the partial lo is discarded and no write is issued.
- Boundaries:
  - Header N=INST_DEPTH is legal; the last write goes to inst_addr=INST_DEPTH-1.
  - Header N=1 completes after one word pair.
  - Reset mid-load aborts immediately with no further inst_valid.
- The memory has no back-pressure; the loader assumes every inst_valid pulse is consumed.

Test Plan:
1. Reset, release, header 5, then word pairs (lo,hi): (ffff0000,00000000), (ffffaaaa,00000000), (ffffbbbb,00000000), (ffffcccc,00000000), (ffffdddd,00000000), one word per cycle.
   - Expect 5 single-cycle inst_valid pulses, every other cycle.
   - inst_out = 64'h00000000ffff0000 .. 64'h00000000ffffdddd; inst_addr 0..4.
   - load_done=1 with the 5th pulse; in_ready=0 afterwards.
2. Header 0 -> load_err=1 next cycle, in_ready=0, no inst_valid. Header 17 (INST_DEPTH=16) after clear -> same result.
3. Header 2 with in_valid toggled 1/0 every cycle and three idle cycles between lo and hi.
   - Exactly 2 pulses, inst_addr 0 then 1.
   - busy=1 throughout the gaps; inst_out stable between pulses.
4. Header 3; after the first instruction, send a lo word, then assert clear in the same cycle as the next hi beat.
   - No second pulse; state IDLE; busy=0.
   - A new header 1 plus pair (12345678,9abcdef0) -> inst_out=64'h9abcdef012345678 at inst_addr 0, load_done=1.
5. Header 16 -> 16 pulses at inst_addr 0..15 with no wrap; a 17th word pair offered afterwards is refused (in_ready=0).
6. Drive rst low mid-load, after 2 of 4 instructions.
   - All outputs 0 immediately (asynchronous), with no clock edge required.
   - After release, in_ready=1 and the next beat is parsed as a header.
